// File: rtl/inst_seq_ctrl_pkg.sv
// Shared encodings for the rysyCore fetch-stage sequencer.
// Holds the inst_sel encodings seen by inst_mgmt, the sequencer state codes
// and the exit-target helper shared by all timed states.
package inst_seq_ctrl_pkg;

  localparam int unsigned SEL_W       = 2;
  localparam int unsigned STATE_W     = 3;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned STALL_CNT_W = 16;

  // Instruction select driven to inst_mgmt; 2'd3 is never produced.
  typedef enum logic [SEL_W-1:0] {
    INST_NOP = 2'd0,
    INST_MEM = 2'd1,
    INST_OLD = 2'd2
  } inst_sel_e;

  // Sequencer state codes, also exported on ctrl_state for debug.
  typedef enum logic [STATE_W-1:0] {
    ST_BOOT     = 3'd0,
    ST_RUN      = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_STALL    = 3'd3,
    ST_WAIT_MEM = 3'd4
  } ctrl_state_e;

  // Where a timed state goes when it ends: straight to RUN only if fetch data is valid.
  function automatic ctrl_state_e exit_target(input logic mem_ready);
    return mem_ready ? ST_RUN : ST_WAIT_MEM;
  endfunction

endpackage

// File: rtl/inst_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i   - clock
//   clr_i   - synchronous clear (highest priority)
//   inc_i   - increment request; ignored once the count is all ones
//   count_o - current count
module inst_seq_ctrl_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, then increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/inst_seq_ctrl.sv
// Fetch-stage pipeline sequencer: sole driver of inst_mgmt's inst_sel.
// Chooses fresh memory word, held instruction or NOP each cycle and keeps the
// fetch PC hold/load consistent with that choice.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   branch_taken  - execute resolved a taken branch/jump this cycle
//   load_use      - decode detected a load-use dependency this cycle
//   mem_ready     - instruction memory rdata valid this cycle
//   inst_sel      - INST_NOP / INST_MEM / INST_OLD to inst_mgmt (registered)
//   pc_hold       - fetch PC keeps its value (registered)
//   pc_load       - fetch PC loads the branch target this cycle (combinational)
//   ctrl_state    - current state code, debug only
//   stall_cnt     - saturating count of non-INST_MEM cycles outside BOOT
module inst_seq_ctrl
  import inst_seq_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_DEPTH  = 2,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned STALL_DEPTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_taken,
  input  logic                   load_use,
  input  logic                   mem_ready,
  output logic [SEL_W-1:0]       inst_sel,
  output logic                   pc_hold,
  output logic                   pc_load,
  output logic [STATE_W-1:0]     ctrl_state,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  inst_sel_e        inst_sel_q, inst_sel_d;
  logic             pc_hold_q, pc_hold_d;

  // Next-state and residency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    case (state_q)
      ST_BOOT: begin
        if (cnt_q == CNT_W'(1)) state_d = exit_target(mem_ready);
      end
      ST_RUN: begin
        if (branch_taken) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_DEPTH);
        end else if (load_use) begin
          state_d = ST_STALL;
          cnt_d   = CNT_W'(STALL_DEPTH);
        end else if (!mem_ready) begin
          state_d = ST_WAIT_MEM;
        end
      end
      // Flushed slots are invalid, so their branch/load_use are ignored.
      ST_FLUSH: begin
        if (cnt_q == CNT_W'(1)) state_d = exit_target(mem_ready);
      end
      ST_STALL: begin
        if (branch_taken) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_DEPTH);
        end else if (cnt_q == CNT_W'(1)) begin
          // A fresh hazard on the last stall cycle extends the stall.
          if (load_use) begin
            cnt_d = CNT_W'(STALL_DEPTH);
          end else begin
            state_d = exit_target(mem_ready);
          end
        end
      end
      ST_WAIT_MEM: begin
        if (branch_taken) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_DEPTH);
        end else if (mem_ready) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
        cnt_d   = CNT_W'(BOOT_DEPTH);
      end
    endcase
  end

  // Moore decode of the upcoming state so the registered outputs track state_q.
  always_comb begin
    inst_sel_d = INST_NOP;
    pc_hold_d  = 1'b1;
    case (state_d)
      ST_RUN: begin
        inst_sel_d = INST_MEM;
        pc_hold_d  = 1'b0;
      end
      ST_FLUSH: pc_hold_d  = 1'b0;
      ST_STALL: inst_sel_d = INST_OLD;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      cnt_q      <= CNT_W'(BOOT_DEPTH);
      inst_sel_q <= INST_NOP;
      pc_hold_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inst_sel_q <= inst_sel_d;
      pc_hold_q  <= pc_hold_d;
    end
  end

  assign inst_sel   = inst_sel_q;
  assign pc_hold    = pc_hold_q;
  assign ctrl_state = state_q;
  assign pc_load    = !rst && branch_taken &&
                      (state_q inside {ST_RUN, ST_STALL, ST_WAIT_MEM});

  // Count every non-MEM cycle once boot has finished.
  inst_seq_ctrl_sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .clr_i  (rst),
    .inc_i  ((state_q != ST_BOOT) && (inst_sel_q != INST_MEM)),
    .count_o(stall_cnt)
  );

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Self-checking bench for inst_seq_ctrl: directed scenarios, random traffic
// and a long saturation run, all compared against a cycle-level model kept
// as "cycles remaining" per activity.
module tb_inst_seq_ctrl;
  import inst_seq_ctrl_pkg::*;

  localparam int unsigned BOOT_D  = 2;
  localparam int unsigned FLUSH_D = 2;
  localparam int unsigned STALL_D = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic        load_use = 1'b0;
  logic        mem_ready = 1'b1;
  logic [1:0]  inst_sel;
  logic        pc_hold;
  logic        pc_load;
  logic [2:0]  ctrl_state;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model: cycles left of boot / flush / stall, waiting-for-memory flag, stall count.
  int m_boot, m_flush, m_stall, m_cnt;
  bit m_wait;

  always #5 clk = ~clk;

  inst_seq_ctrl #(
    .BOOT_DEPTH (BOOT_D),
    .FLUSH_DEPTH(FLUSH_D),
    .STALL_DEPTH(STALL_D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .branch_taken(branch_taken),
    .load_use    (load_use),
    .mem_ready   (mem_ready),
    .inst_sel    (inst_sel),
    .pc_hold     (pc_hold),
    .pc_load     (pc_load),
    .ctrl_state  (ctrl_state),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_boot  = BOOT_D;
    m_flush = 0;
    m_stall = 0;
    m_wait  = 1'b0;
    m_cnt   = 0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic r, input logic b, input logic l, input logic m);
    logic [1:0] e_sel;
    logic       e_hold;
    logic       e_load;
    logic [2:0] e_st;
    @(negedge clk);
    rst = r; branch_taken = b; load_use = l; mem_ready = m;
    #1;
    if (m_boot > 0) begin
      e_sel = 2'd0; e_hold = 1'b1; e_st = 3'd0;
    end else if (m_flush > 0) begin
      e_sel = 2'd0; e_hold = 1'b0; e_st = 3'd2;
    end else if (m_stall > 0) begin
      e_sel = 2'd2; e_hold = 1'b1; e_st = 3'd3;
    end else if (m_wait) begin
      e_sel = 2'd0; e_hold = 1'b1; e_st = 3'd4;
    end else begin
      e_sel = 2'd1; e_hold = 1'b0; e_st = 3'd1;
    end
    e_load = !r && b && (m_boot == 0) && (m_flush == 0);
    chk("inst_sel",   16'(inst_sel),   16'(e_sel));
    chk("pc_hold",    16'(pc_hold),    16'(e_hold));
    chk("pc_load",    16'(pc_load),    16'(e_load));
    chk("ctrl_state", 16'(ctrl_state), 16'(e_st));
    chk("stall_cnt",  stall_cnt,       16'(m_cnt));
    if (r) begin
      model_reset();
    end else begin
      if (m_boot == 0 && e_sel != 2'd1) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (m_boot > 0) begin
        m_boot--;
        if (m_boot == 0) m_wait = !m;
      end else if (m_flush > 0) begin
        m_flush--;
        if (m_flush == 0) m_wait = !m;
      end else if (m_stall > 0) begin
        if (b) begin
          m_stall = 0;
          m_flush = FLUSH_D;
        end else if (m_stall == 1 && l) begin
          m_stall = STALL_D;
        end else begin
          m_stall--;
          if (m_stall == 0) m_wait = !m;
        end
      end else if (m_wait) begin
        if (b) begin
          m_wait  = 1'b0;
          m_flush = FLUSH_D;
        end else if (m) begin
          m_wait = 1'b0;
        end
      end else begin
        if (b)       m_flush = FLUSH_D;
        else if (l)  m_stall = STALL_D;
        else if (!m) m_wait  = 1'b1;
      end
    end
  endtask

  initial begin
    logic r_v, b_v, l_v, m_v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset held, release, boot NOPs then RUN.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Branch in RUN, further branch pulses during FLUSH ignored.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Load-use stall.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Branch pre-empts the stall on its second cycle.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

    // New hazard on the last stall cycle extends the stall.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Memory wait in RUN.
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

    // FLUSH ending with memory not ready goes to WAIT_MEM.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while waiting on memory.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic with occasional resets.
    repeat (3000) begin
      r_v = ($urandom_range(0, 99) == 0);
      b_v = ($urandom_range(0, 9) == 0);
      l_v = ($urandom_range(0, 6) == 0);
      m_v = ($urandom_range(0, 4) != 0);
      step(r_v, b_v, l_v, m_v);
    end

    // Long memory wait drives stall_cnt into saturation.
    repeat (70000) step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_cnt_sat", stall_cnt, 16'hFFFF);

    // Reset clears the saturated count.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
